// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: decodes the instruction word from the datapath
// and sequences FETCH/DECODE/EXEC/MEM/WB, driving every datapath control input.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       regdst,
  output logic             isbeq,
  output logic [3:0]       memtoreg,
  output logic             regwrite,
  output logic             memwrite,
  output logic             alusrc,
  output logic [1:0]       extop,
  output logic [1:0]       cpcop,
  output logic             cpc,
  output logic [1:0]       aluctrl,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  logic [2:0] state;
  logic [2:0] state_next;
  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
  logic is_alu, is_mem, is_known;

  logic ir_en_c, pc_en_c, regwrite_c, memwrite_c, cpc_c;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign unused_bits = ^instr[25:6];

  assign is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_jal   = (op == OP_JAL);
  assign is_alu   = is_addu | is_subu | is_ori | is_lui;
  assign is_mem   = is_lw | is_sw;
  assign is_known = is_alu | is_mem | is_beq | is_jal | is_jr;

  // Select fields follow the held instruction in every state, but read as idle values while reset is low
  always_comb begin
    regdst   = 2'b00;
    memtoreg = 4'b0001;
    alusrc   = 1'b0;
    extop    = 2'b00;
    aluctrl  = 2'b00;
    cpcop    = 2'b00;
    isbeq    = 1'b0;
    if (reset) begin
      if (is_addu || is_subu) regdst = 2'b01;
      if (is_jal)             regdst = 2'b10;
      if (is_lw)              memtoreg = 4'b0010;
      if (is_lui)             memtoreg = 4'b0100;
      if (is_jal)             memtoreg = 4'b1000;
      if (is_ori || is_lui || is_mem) alusrc = 1'b1;
      if (is_mem || is_beq)   extop = 2'b01;
      if (is_lui)             extop = 2'b10;
      if (is_subu || is_beq)  aluctrl = 2'b01;
      if (is_ori)             aluctrl = 2'b10;
      if (is_beq)             cpcop = 2'b01;
      if (is_jal)             cpcop = 2'b10;
      if (is_jr)              cpcop = 2'b11;
      isbeq = is_beq;
    end
  end

  always_comb begin
    state_next = state;
    ir_en_c    = 1'b0;
    pc_en_c    = 1'b0;
    regwrite_c = 1'b0;
    memwrite_c = 1'b0;
    cpc_c      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_en_c    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_known) begin
          state_next = S_EXEC;
        end else begin
          pc_en_c    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_mem) begin
          state_next = S_MEM;
        end else if (is_alu) begin
          state_next = S_WB;
        end else if (is_beq || is_jr) begin
          pc_en_c    = 1'b1;
          cpc_c      = 1'b1;
          state_next = S_FETCH;
        end else if (is_jal) begin
          regwrite_c = 1'b1;
          pc_en_c    = 1'b1;
          cpc_c      = 1'b1;
          state_next = S_FETCH;
        end else begin
          pc_en_c    = 1'b1;
          state_next = S_FETCH;
        end
      end
      // A store keeps strobing the memory until it acknowledges, then retires in the same cycle
      S_MEM: begin
        if (is_sw) begin
          memwrite_c = 1'b1;
          if (mem_ready) begin
            pc_en_c    = 1'b1;
            state_next = S_FETCH;
          end
        end else if (is_lw) begin
          if (mem_ready) state_next = S_WB;
        end else begin
          pc_en_c    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        regwrite_c = 1'b1;
        pc_en_c    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign ir_en    = reset & ir_en_c;
  assign pc_en    = reset & pc_en_c;
  assign regwrite = reset & regwrite_c;
  assign memwrite = reset & memwrite_c;
  assign cpc      = reset & cpc_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // One pc_en pulse per instruction, so counting pulses counts retired instructions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt <= '0;
    end else if (pc_en) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected strobe events,
// a negedge monitor pops one whenever the controller raises any strobe.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        ir_en, pc_en, isbeq, regwrite, memwrite, alusrc, cpc;
  logic [1:0]  regdst, extop, cpcop, aluctrl;
  logic [3:0]  memtoreg;
  logic [3:0]  instr_cnt;

  typedef struct {
    int         cyc;
    logic [3:0] strb;
    logic [1:0] regdst;
    logic [3:0] mtr;
    logic [1:0] cpcop;
    logic       isbeq;
    logic [1:0] alu;
    logic [1:0] extop;
    logic       alusrc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         retired  = 0;
  int         mon_cyc  = 0;
  logic [3:0] exp_cnt  = 4'd0;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .ir_en(ir_en), .pc_en(pc_en), .regdst(regdst), .isbeq(isbeq),
    .memtoreg(memtoreg), .regwrite(regwrite), .memwrite(memwrite),
    .alusrc(alusrc), .extop(extop), .cpcop(cpcop), .cpc(cpc),
    .aluctrl(aluctrl), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int cyc, input logic [3:0] strb, input logic [1:0] rd,
                         input logic [3:0] mtr, input logic [1:0] cop, input logic beq,
                         input logic [1:0] alu, input logic [1:0] ext, input logic asrc);
    exp_t e;
    e.cyc = cyc; e.strb = strb; e.regdst = rd; e.mtr = mtr; e.cpcop = cop;
    e.isbeq = beq; e.alu = alu; e.extop = ext; e.alusrc = asrc; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Issue one instruction at the start of its FETCH cycle and wait for it to retire
  task automatic apply_stimulus(input logic [31:0] word, input int wait_cycles, input logic ready_init);
    int start;
    instr     = word;
    mem_ready = ready_init;
    start     = retired;
    if (wait_cycles > 0) begin
      repeat (3 + wait_cycles) @(posedge clk);
      #1 mem_ready = 1'b1;
    end
    for (int i = 0; i < 40 && retired == start; i++) @(posedge clk);
    check_output("retire_seen", {31'b0, retired != start}, 32'd1);
    #1;
    exp_cnt = exp_cnt + 4'd1;
    check_output("instr_cnt", {28'b0, instr_cnt}, {28'b0, exp_cnt});
  endtask

  task automatic check_reset_outputs(input string name);
    check_output(name, {12'b0, ir_en, pc_en, regwrite, memwrite, cpc, regdst, isbeq,
                        memtoreg, alusrc, extop, cpcop, aluctrl},
                 {12'b0, 5'b0, 2'b00, 1'b0, 4'b0001, 1'b0, 2'b00, 2'b00, 2'b00});
    check_output({name, "_cnt"}, {28'b0, instr_cnt}, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      mon_cyc = 0;
    end else begin
      mon_cyc = mon_cyc + 1;
      check_output("ir_en", {31'b0, ir_en}, {31'b0, mon_cyc == 1});
      if (pc_en || regwrite || memwrite || cpc) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", {28'b0, pc_en, regwrite, memwrite, cpc}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("event_cycle", mon_cyc, e.cyc);
          check_output("event_fields",
            {10'b0, pc_en, regwrite, memwrite, cpc, regdst, memtoreg, cpcop, isbeq, aluctrl, extop, alusrc, instr_cnt},
            {10'b0, e.strb, e.regdst, e.mtr, e.cpcop, e.isbeq, e.alu, e.extop, e.alusrc, e.cnt});
        end
      end
      if (pc_en) begin
        mon_cyc = 0;
        retired++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b0;
    instr     = 32'h0C000010;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_idle");

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_ev(2, 4'b1000, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
      apply_stimulus(32'h00000000, 0, 1'b1);
    end

    push_ev(4, 4'b1100, 2'b01, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h00221821, 0, 1'b1);
    push_ev(4, 4'b1100, 2'b01, 4'b0001, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
    apply_stimulus(32'h00221823, 0, 1'b1);
    push_ev(4, 4'b1100, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1);
    apply_stimulus(32'h34220005, 0, 1'b1);
    push_ev(4, 4'b1100, 2'b00, 4'b0100, 2'b00, 1'b0, 2'b00, 2'b10, 1'b1);
    apply_stimulus(32'h3C020012, 0, 1'b1);

    push_ev(8, 4'b1100, 2'b00, 4'b0010, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1);
    apply_stimulus(32'h8C220004, 3, 1'b0);
    push_ev(5, 4'b1100, 2'b00, 4'b0010, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1);
    apply_stimulus(32'h8C220004, 0, 1'b1);

    push_ev(4, 4'b1010, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1);
    apply_stimulus(32'hAC220004, 0, 1'b1);
    push_ev(4, 4'b0010, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1);
    push_ev(5, 4'b1010, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b01, 1'b1);
    apply_stimulus(32'hAC220004, 1, 1'b0);

    push_ev(3, 4'b1001, 2'b00, 4'b0001, 2'b01, 1'b1, 2'b01, 2'b01, 1'b0);
    apply_stimulus(32'h10220003, 0, 1'b1);
    push_ev(3, 4'b1101, 2'b10, 4'b1000, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h0C000010, 0, 1'b1);
    push_ev(3, 4'b1001, 2'b00, 4'b0001, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h03E00008, 0, 1'b1);
    push_ev(2, 4'b1000, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'hFC000000, 0, 1'b1);

    // Sixteenth retirement: mem_ready low must not stall an ALU op, and the 4-bit count wraps to 0
    push_ev(4, 4'b1100, 2'b01, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h00221821, 0, 1'b0);
    push_ev(2, 4'b1000, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h00000000, 0, 1'b1);

    instr     = 32'h8C220004;
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_outputs("reset_mid_lw");
    exp_cnt = 4'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    push_ev(2, 4'b1000, 2'b00, 4'b0001, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h00000000, 0, 1'b1);
    push_ev(3, 4'b1001, 2'b00, 4'b0001, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
    apply_stimulus(32'h03E00008, 0, 1'b1);

    repeat (2) @(posedge clk);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
